// File: rtl/gpio_rgb_collector.sv
// Collects R/G/B plane words from the processor GPIO and streams 24-bit pixels.
// Optional frame checksum output enabled by GPIO_COLLECTOR_CHECKSUM_EN.
module gpio_rgb_collector #(
    parameter int WORDS = 40000,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      gpio_i,
    input  logic             arm_i,
    input  logic             en_r_i,
    input  logic             en_g_i,
    input  logic             en_b_i,
    output logic [23:0]      pix_o,
    output logic             pix_valid_o,
    input  logic             pix_ready_i,
    output logic             pix_last_o,
    output logic [CNT_W-1:0] word_cnt_o,
    output logic             done_o,
    output logic             ovf_o,
    output logic             seq_err_o
`ifdef GPIO_COLLECTOR_CHECKSUM_EN
    ,
    output logic [31:0]      checksum_o
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WORDS);
    localparam logic [CNT_W-1:0] LAST_BANK = CNT_W'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        EXP_R,
        EXP_G,
        EXP_B,
        DONE
    } state_t;

    state_t           state;
    state_t           state_n;

    logic [1:0][31:0] bank_r;
    logic [1:0][31:0] bank_g;
    logic [1:0][31:0] bank_b;
    logic [1:0]       full;
    logic             wp;
    logic             rp;

    logic             drop;
    logic             drop_n;
    logic             st_r;
    logic             st_g;
    logic             st_b;
    logic             set_err;
    logic             set_ovf;
    logic             multi;
    logic             bank_free;
    logic [CNT_W-1:0] cnt_inc;

    logic [CNT_W-1:0] emit_cnt;
    logic [1:0]       k;
    logic [1:0]       ld_k;
    logic [4:0]       ld_sh;
    logic [23:0]      ld_pix;
    logic             accept;
    logic             emit_free;

    assign multi = (en_r_i & en_g_i) | (en_r_i & en_b_i) | (en_g_i & en_b_i);

    assign accept    = pix_valid_o & pix_ready_i;
    assign emit_free = accept & (k == 2'd3);

    // A bank being released by the emitter this edge may be refilled this edge.
    assign bank_free = ~full[wp] | (emit_free & (rp == wp));

    assign cnt_inc = word_cnt_o + CNT_W'(1);

    assign pix_last_o = pix_valid_o & (k == 2'd3) & (emit_cnt == LAST_BANK);

    assign ld_k   = pix_valid_o ? k + 2'd1 : 2'd0;
    assign ld_sh  = {ld_k, 3'b000};
    assign ld_pix = {bank_r[rp][ld_sh +: 8],
                     bank_g[rp][ld_sh +: 8],
                     bank_b[rp][ld_sh +: 8]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            drop  <= 1'b0;
        end else begin
            state <= state_n;
            drop  <= drop_n;
        end
    end

    always_comb begin
        state_n = state;
        drop_n  = drop;
        st_r    = 1'b0;
        st_g    = 1'b0;
        st_b    = 1'b0;
        set_err = 1'b0;
        set_ovf = 1'b0;
        unique case (state)
            IDLE: begin
                if (arm_i) state_n = EXP_R;
            end
            EXP_R: begin
                if (multi) begin
                    set_err = 1'b1;
                    drop_n  = 1'b0;
                end else if (en_r_i) begin
                    drop_n = 1'b0;
                    if (bank_free) begin
                        st_r    = 1'b1;
                        state_n = EXP_G;
                    end else begin
                        set_ovf = 1'b1;
                        drop_n  = 1'b1;
                    end
                end else if (en_g_i) begin
                    if (!drop) set_err = 1'b1;
                end else if (en_b_i) begin
                    if (drop) drop_n = 1'b0;
                    else      set_err = 1'b1;
                end
            end
            EXP_G: begin
                if (multi) begin
                    set_err = 1'b1;
                    state_n = EXP_R;
                end else if (en_g_i) begin
                    st_g    = 1'b1;
                    state_n = EXP_B;
                end else if (en_r_i) begin
                    // the partial bank is never full, so the restart R fits
                    set_err = 1'b1;
                    st_r    = 1'b1;
                end else if (en_b_i) begin
                    set_err = 1'b1;
                    state_n = EXP_R;
                end
            end
            EXP_B: begin
                if (multi) begin
                    set_err = 1'b1;
                    state_n = EXP_R;
                end else if (en_b_i) begin
                    st_b    = 1'b1;
                    state_n = (cnt_inc == LAST_CNT) ? DONE : EXP_R;
                end else if (en_r_i) begin
                    set_err = 1'b1;
                    st_r    = 1'b1;
                    state_n = EXP_G;
                end else if (en_g_i) begin
                    set_err = 1'b1;
                    state_n = EXP_R;
                end
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            bank_r      <= '0;
            bank_g      <= '0;
            bank_b      <= '0;
            full        <= '0;
            wp          <= 1'b0;
            rp          <= 1'b0;
            word_cnt_o  <= '0;
            emit_cnt    <= '0;
            k           <= 2'd0;
            pix_o       <= '0;
            pix_valid_o <= 1'b0;
            done_o      <= 1'b0;
            ovf_o       <= 1'b0;
            seq_err_o   <= 1'b0;
        end else begin
            if (set_err) seq_err_o <= 1'b1;
            if (set_ovf) ovf_o <= 1'b1;
            if (st_r) bank_r[wp] <= gpio_i;
            if (st_g) bank_g[wp] <= gpio_i;

            if (emit_free) begin
                full[rp]    <= 1'b0;
                rp          <= ~rp;
                k           <= 2'd0;
                pix_o       <= '0;
                pix_valid_o <= 1'b0;
                if (emit_cnt != LAST_CNT) emit_cnt <= emit_cnt + CNT_W'(1);
                if (pix_last_o) done_o <= 1'b1;
            end else if (accept) begin
                k     <= ld_k;
                pix_o <= ld_pix;
            end else if (!pix_valid_o && full[rp]) begin
                k           <= ld_k;
                pix_o       <= ld_pix;
                pix_valid_o <= 1'b1;
            end

            // placed after the release so a refill of the same bank wins
            if (st_b) begin
                bank_b[wp] <= gpio_i;
                full[wp]   <= 1'b1;
                wp         <= ~wp;
                if (word_cnt_o != LAST_CNT) word_cnt_o <= cnt_inc;
            end
        end
    end

`ifdef GPIO_COLLECTOR_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            checksum_o <= '0;
        end else if (accept && !done_o) begin
            checksum_o <= checksum_o + {8'h00, pix_o};
        end
    end
`endif

endmodule
